spi_reg_sequencer: RTL
======================

# spi_reg_sequencer

Command sequencer between `block_spi_slave` and the design's control registers. It consumes each address/data pair the slave flags with `data_ready` and decodes it into a register write. It owns a small register bank and enforces a two-byte unlock sequence before protected registers can be written. It sits directly downstream of the SPI slave, and its register contents drive LEDs, ECG front-end configuration and similar controls.

## Interface
Parameters:
- `NUM_REGS`, 8: number of 8-bit registers, a power of two between 2 and 64.
- `PROT_BASE`, 4: register addresses at or above this value are protected.
- `UNLOCK_TIMEOUT`, 1024: number of `clk` cycles after which an unlock or partial unlock expires.

Ports:
- `clk`, in, 1: system clock, the same clock driven by `block_clock`.
- `rst`, in, 1: synchronous, active-high reset.
- `cs_n`, in, 1: SPI chip select, active low, already synchronised to `clk`.
- `rx_valid`, in, 1: single-cycle pulse, driven from the slave's `data_ready`.
- `rx_address`, in, 8: register address for the received pair.
- `rx_data`, in, 8: write data for the received pair.
- `reg_q`, out, `NUM_REGS`*8: flattened register contents; register i occupies bits [8i+7:8i].
- `wr_strobe`, out, 1: one-cycle pulse for each accepted write.
- `wr_addr`, out, clog2(`NUM_REGS`): address of the last accepted write.
- `locked`, out, 1: high unless the FSM is in UNLOCKED.
- `err_count`, out, 8: count of rejected pairs, saturating at 255.

## Operation
- The FSM has three states: LOCKED, KEY1 and UNLOCKED.
- Each `rx_valid` is classified in priority order:
  1. `cs_n` is high: reject.
  2. `rx_address` equals KEY_ADDR (0x7F): key write; no register changes.
  3. `rx_address` is at or above `NUM_REGS`: reject.
  4. The address is protected and the FSM is not in UNLOCKED: reject.
  5. Otherwise: accept; write `rx_data` to the register, set `wr_addr`, pulse `wr_strobe`.
- Every reject increments `err_count` (saturating); nothing else changes.
- FSM transitions on key writes:
  - From LOCKED, data 0xA5 moves to KEY1. Any other value keeps LOCKED and counts as an error.
  - From KEY1, data 0x5A moves to UNLOCKED. Any other value returns to LOCKED and counts as an error.
  - From UNLOCKED, data 0x00 returns to LOCKED. Any other value is ignored.
- In KEY1, any non-key pair, whether accepted or rejected, aborts the sequence and returns the FSM to LOCKED. The pair itself is still classified as above.
- The FSM returns to LOCKED from KEY1 or UNLOCKED when either of these occurs:
  - a `cs_n` rising edge (end of transaction);
  - the timeout counter reaching `UNLOCK_TIMEOUT`-1. The counter clears on entry to KEY1 or UNLOCKED and counts every cycle while in either state.

## Timing
- Reset values:
  - all `reg_q` bytes are 0x00;
  - `wr_strobe` is 0, `wr_addr` is 0, `err_count` is 0;
  - the FSM is in LOCKED and `locked` is 1;
  - the timeout counter is 0;
  - the registered previous value of `cs_n` is 1.
- Reset mid-sequence discards any partial unlock immediately.
- Latency: `rx_valid` at cycle N produces the updated `reg_q`, the `wr_strobe` pulse and the new FSM state/`locked` value at cycle N+1.
- Back-to-back `rx_valid` pulses on consecutive cycles are all processed. There is no stall or backpressure.
- Same-cycle `rx_valid` and `cs_n` rising edge: the pair is classified using the current `cs_n` value, which is high, so it is rejected. The relock also takes effect at N+1.
- Same-cycle timeout expiry and `rx_valid`: the pair is classified against the pre-timeout state, and the FSM is in LOCKED at N+1.
- `err_count` holds at 255 and does not wrap.

## Configuration
- `SPI_SEQ_WRITE_PROTECT_EN` defined:
  - protection FSM, timeout counter and key handling as described above.
- `SPI_SEQ_WRITE_PROTECT_EN` undefined:
  - FSM and timeout counter are removed;
  - `locked` is tied to 0;
  - every in-range write is accepted;
  - writes to KEY_ADDR are silently ignored and are not counted as errors.

## Structure
- Package `spi_seq_pkg` holds:
  - constants KEY_ADDR = 8'h7F, KEY1_VAL = 8'hA5, KEY2_VAL = 8'h5A, RELOCK_VAL = 8'h00;
  - the state enum `seq_state_t` (LOCKED, KEY1, UNLOCKED).
- Sub-module `spi_unlock_fsm` contains the FSM and timeout counter. It takes the classified key-write and abort events plus the `cs_n` edge, and outputs `unlocked`. The whole sub-module is excluded when the macro is undefined.

## Test plan
- Reset, then write (0x01, 0x3C) with `cs_n` low: `reg_q[15:8]` is 0x3C and `wr_strobe` pulses once with `wr_addr` = 1, at N+1.
- Write (0x05, 0x11) while locked: register 5 stays 0x00 and `err_count` becomes 1.
- Key sequence 0xA5 then 0x5A, then write (0x05, 0x11): `locked` = 0 and register 5 is 0x11. Raising `cs_n` gives `locked` = 1 on the next cycle.
- Key 0xA5, then write (0x02, 0x77), then key 0x5A: register 2 is 0x77, the FSM is in LOCKED, and `err_count` increments by 1.
- Unlock, then idle for `UNLOCK_TIMEOUT` cycles: `locked` returns to 1, and a following write to 0x06 is rejected.
- 300 writes to address 0x20: `err_count` reads 255. With the macro undefined, a write (0x06, 0x42) is accepted directly.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
// Shared constants and types for the SPI register sequencer.
//   KEY_ADDR   : address reserved for the unlock/relock key writes
//   KEY1_VAL   : first byte of the unlock sequence
//   KEY2_VAL   : second byte of the unlock sequence
//   RELOCK_VAL : key byte that relocks an unlocked bank
//   seq_state_t: protection FSM states (LOCKED, KEY1, UNLOCKED)
package spi_seq_pkg;

  localparam logic [7:0] KEY_ADDR   = 8'h7F;
  localparam logic [7:0] KEY1_VAL   = 8'hA5;
  localparam logic [7:0] KEY2_VAL   = 8'h5A;
  localparam logic [7:0] RELOCK_VAL = 8'h00;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spi_unlock_fsm.sv
// spi_unlock_fsm
// Write-protection state machine with an inactivity timeout. Only built
// when SPI_SEQ_WRITE_PROTECT_EN is defined.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   key_write   : a valid pair addressed to KEY_ADDR while cs_n is low
//   key_data    : data byte of that key write
//   abort       : any other pair this cycle (cancels a half-entered key)
//   cs_rise     : rising edge of cs_n (end of SPI transaction)
//   unlocked    : high while protected registers may be written
//   key_reject  : combinational, a key write with the wrong byte
`ifdef SPI_SEQ_WRITE_PROTECT_EN
module spi_unlock_fsm
  import spi_seq_pkg::*;
#(
  parameter int UNLOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_write,
  input  logic [7:0] key_data,
  input  logic       abort,
  input  logic       cs_rise,
  output logic       unlocked,
  output logic       key_reject
);

  localparam int CW = ($clog2(UNLOCK_TIMEOUT) > 0) ? $clog2(UNLOCK_TIMEOUT) : 1;

  seq_state_t    state;
  seq_state_t    state_next;
  logic [CW-1:0] cnt;
  logic          timeout;

  // The counter runs only outside LOCKED, so expiry is meaningful only there.
  assign timeout  = (state != LOCKED) && (cnt == CW'(UNLOCK_TIMEOUT - 1));
  assign unlocked = (state == UNLOCKED);

  // State register; reset drops any partially entered key immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKED;
    end else begin
      state <= state_next;
    end
  end

  // Timeout counter: cleared on entry to KEY1/UNLOCKED and held at zero in
  // LOCKED, otherwise it counts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next == LOCKED || state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Key decoding. The relock events (cs_n edge, timeout) are applied last so
  // they override whatever the key write of the same cycle asked for; the
  // key write is still judged against the current state for error counting.
  always_comb begin
    state_next = state;
    key_reject = 1'b0;
    case (state)
      LOCKED: begin
        if (key_write) begin
          if (key_data == KEY1_VAL) state_next = KEY1;
          else                      key_reject = 1'b1;
        end
      end
      KEY1: begin
        if (key_write) begin
          if (key_data == KEY2_VAL) begin
            state_next = UNLOCKED;
          end else begin
            state_next = LOCKED;
            key_reject = 1'b1;
          end
        end else if (abort) begin
          state_next = LOCKED;
        end
      end
      UNLOCKED: begin
        if (key_write && key_data == RELOCK_VAL) state_next = LOCKED;
      end
      default: state_next = LOCKED;
    endcase
    if (state != LOCKED && (cs_rise || timeout)) state_next = LOCKED;
  end

endmodule
`endif

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer
// Decodes address/data pairs from the SPI slave into writes to a small
// register bank, with optional write protection of the upper registers.
// Build option: SPI_SEQ_WRITE_PROTECT_EN enables the unlock FSM, timeout
// and key handling; without it every in-range write is accepted, key writes
// are ignored and locked is tied low.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   cs_n                  : SPI chip select (active low, already synchronised)
//   rx_valid              : one-cycle pulse per received pair
//   rx_address, rx_data   : received register address and write data
//   reg_q                 : flattened register bank, register i at [8i+7:8i]
//   wr_strobe             : one-cycle pulse per accepted write
//   wr_addr               : address of the last accepted write
//   locked                : high unless protected registers are writable
//   err_count             : saturating count of rejected pairs
module spi_reg_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int PROT_BASE      = 4,
  parameter int UNLOCK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_address,
  input  logic [7:0]                  rx_data,
  output logic [NUM_REGS*8-1:0]       reg_q,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic                        locked,
  output logic [7:0]                  err_count
);

  localparam int AW = $clog2(NUM_REGS);

  // Elaboration-time guards on the parameter ranges the design relies on.
  if (NUM_REGS < 2 || NUM_REGS > 64 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("NUM_REGS must be a power of two between 2 and 64");
  end
  if (PROT_BASE < 0 || UNLOCK_TIMEOUT < 2) begin : g_bad_params
    $error("PROT_BASE must be non-negative and UNLOCK_TIMEOUT at least 2");
  end

  logic [7:0]    regs [NUM_REGS];
  logic [AW-1:0] idx;
  logic          is_key;
  logic          in_range;
  logic          accept;
  logic          reject;

  assign idx      = rx_address[AW-1:0];
  assign is_key   = (rx_address == KEY_ADDR);
  assign in_range = ({24'd0, rx_address} < 32'(NUM_REGS));

`ifdef SPI_SEQ_WRITE_PROTECT_EN
  logic cs_prev;
  logic cs_rise;
  logic is_prot;
  logic key_write;
  logic abort;
  logic unlocked;
  logic key_reject;

  assign is_prot   = ({24'd0, rx_address} >= 32'(PROT_BASE));
  assign cs_rise   = cs_n && !cs_prev;
  // A pair sent with cs_n high is rejected before the key check, so it is
  // never treated as a key write.
  assign key_write = rx_valid && !cs_n && is_key;
  assign abort     = rx_valid && !key_write;
  assign accept    = rx_valid && !cs_n && !is_key && in_range && (!is_prot || unlocked);
  assign reject    = (rx_valid && !key_write && !accept) || key_reject;
  assign locked    = !unlocked;

  // Previous chip-select level for end-of-transaction detection. Reset to
  // high so a bus idling high after reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev <= 1'b1;
    end else begin
      cs_prev <= cs_n;
    end
  end

  spi_unlock_fsm #(
    .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
  ) u_unlock_fsm (
    .clk        (clk),
    .rst        (rst),
    .key_write  (key_write),
    .key_data   (rx_data),
    .abort      (abort),
    .cs_rise    (cs_rise),
    .unlocked   (unlocked),
    .key_reject (key_reject)
  );
`else
  // Without protection, key-address pairs are dropped silently; only a
  // deselected bus or an out-of-range address counts as an error.
  assign accept = rx_valid && !cs_n && !is_key && in_range;
  assign reject = rx_valid && (cs_n || (!is_key && !in_range));
  assign locked = 1'b0;
`endif

  // Register bank, write strobe/address and the saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_count <= 8'h00;
    end else begin
      wr_strobe <= accept;
      if (accept) begin
        regs[idx] <= rx_data;
        wr_addr   <= idx;
      end
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Flatten the bank onto the output bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[8*i +: 8] = regs[i];
  end

endmodule
